// File: rtl/alarm_ring_ctrl_pkg.sv
// Shared types and time-word layout for the alarm ring controller and the time counter.
package alarm_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2
    } alarm_state_e;

    localparam int MERIDIAN_BIT = 17;
    localparam int HOUR_MSB     = 16;
    localparam int HOUR_LSB     = 12;
    localparam int MIN_MSB      = 11;
    localparam int MIN_LSB      = 6;
    localparam int SEC_MSB      = 5;
    localparam int SEC_LSB      = 0;
    localparam int TIME_W       = MERIDIAN_BIT + 1;
    localparam int ALARM_W      = HOUR_MSB + 1;

    function automatic logic [TIME_W-1:0] pack_time(input logic mer, input logic [4:0] hh,
                                                    input logic [5:0] mm, input logic [5:0] ss);
        return {mer, hh, mm, ss};
    endfunction

    // Alarm comparison is 24 h, so the meridian flag must not take part.
    function automatic logic [TIME_W-1:0] strip_meridian(input logic [TIME_W-1:0] t);
        logic [TIME_W-1:0] t_s;
        t_s               = t;
        t_s[MERIDIAN_BIT] = 1'b0;
        return t_s;
    endfunction

endpackage

// File: rtl/alarm_ring_ctrl_if.sv
// Time/alarm inputs, user buttons and buzzer/status outputs of the alarm ring controller.
interface alarm_ring_ctrl_if #(
    parameter int SNZ_W = 2
) ();
    import alarm_pkg::*;

    logic               TICK;
    logic [TIME_W-1:0]  CUR_TIME;
    logic [ALARM_W-1:0] ALARM_TIME;
    logic               ALARM_EN;
    logic               STOP_BTN;
    logic               SNOOZE_BTN;
    logic               BUZZ;
    logic               RINGING;
    logic               SNOOZED;
    logic [SNZ_W-1:0]   SNOOZE_LEFT;

    modport master (
        output TICK, CUR_TIME, ALARM_TIME, ALARM_EN, STOP_BTN, SNOOZE_BTN,
        input  BUZZ, RINGING, SNOOZED, SNOOZE_LEFT
    );

    modport slave (
        input  TICK, CUR_TIME, ALARM_TIME, ALARM_EN, STOP_BTN, SNOOZE_BTN,
        output BUZZ, RINGING, SNOOZED, SNOOZE_LEFT
    );

endinterface

// File: rtl/alarm_ring_ctrl_btn_edge.sv
// Rising-edge detector for a debounced button level.
module btn_edge (
    input  logic CLK,
    input  logic RESETN,
    input  logic btn,
    output logic pulse
);

    logic btn_d;
    logic btn_q;

    // Next value of the delayed button level.
    always_comb begin
        btn_d = btn;
    end

    // Delayed button level register.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            btn_q <= 1'b0;
        end else begin
            btn_q <= btn_d;
        end
    end

    assign pulse = btn & ~btn_q;

endmodule

// File: rtl/alarm_ring_ctrl.sv
// Alarm ring controller: detects alarm-time match, rings the buzzer, handles stop and snooze.
module alarm_ring_ctrl
    import alarm_pkg::*;
#(
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_SEC = 300,
    parameter int MAX_SNOOZE = 3,
    parameter int SNZ_W      = 2
) (
    input  logic             CLK,
    input  logic             RESETN,
    alarm_ring_ctrl_if.slave bus
);

    localparam int RING_W = $clog2(RING_SEC + 1);
    localparam int SCNT_W = $clog2(SNOOZE_SEC + 1);

    alarm_state_e      state_d, state_q;
    logic [RING_W-1:0] ring_cnt_d, ring_cnt_q;
    logic [SCNT_W-1:0] snz_cnt_d, snz_cnt_q;
    logic [SNZ_W-1:0]  snz_left_d, snz_left_q;
    logic              beep_d, beep_q;
    logic              match_d, match_q;
    logic              ringing_d, ringing_q;
    logic              snoozed_d, snoozed_q;
    logic              buzz_d, buzz_q;
    logic              rise_s, stop_s, snooze_s;

    btn_edge u_stop_edge   (.CLK(CLK), .RESETN(RESETN), .btn(bus.STOP_BTN),   .pulse(stop_s));
    btn_edge u_snooze_edge (.CLK(CLK), .RESETN(RESETN), .btn(bus.SNOOZE_BTN), .pulse(snooze_s));

    // Alarm match and its rising edge.
    always_comb begin
        match_d = bus.ALARM_EN & (strip_meridian(bus.CUR_TIME) == {1'b0, bus.ALARM_TIME});
        rise_s  = match_d & ~match_q;
    end

    // Next-state, counters and output decode; disarm overrides every other event.
    always_comb begin
        state_d    = state_q;
        ring_cnt_d = ring_cnt_q;
        snz_cnt_d  = snz_cnt_q;
        snz_left_d = snz_left_q;
        beep_d     = beep_q;
        case (state_q)
            IDLE: begin
                if (rise_s) begin
                    state_d    = RING;
                    ring_cnt_d = '0;
                    beep_d     = 1'b1;
                    snz_left_d = SNZ_W'(MAX_SNOOZE);
                end else begin
                    state_d = IDLE;
                end
            end
            RING: begin
                if (stop_s) begin
                    state_d = IDLE;
                end else if (snooze_s && (snz_left_q != '0)) begin
                    state_d    = SNOOZE;
                    snz_cnt_d  = SCNT_W'(SNOOZE_SEC);
                    snz_left_d = snz_left_q - SNZ_W'(1);
                end else if (bus.TICK) begin
                    ring_cnt_d = ring_cnt_q + RING_W'(1);
                    beep_d     = ~beep_q;
                    state_d    = (ring_cnt_q == RING_W'(RING_SEC - 1)) ? IDLE : RING;
                end else begin
                    state_d = RING;
                end
            end
            SNOOZE: begin
                if (stop_s) begin
                    state_d = IDLE;
                end else if (bus.TICK && (snz_cnt_q == SCNT_W'(1))) begin
                    state_d    = RING;
                    ring_cnt_d = '0;
                    beep_d     = 1'b1;
                end else if (bus.TICK) begin
                    snz_cnt_d = snz_cnt_q - SCNT_W'(1);
                end else begin
                    state_d = SNOOZE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (!bus.ALARM_EN) begin
            state_d = IDLE;
        end else begin
            state_d = state_d;
        end
        snz_left_d = (state_d == IDLE) ? SNZ_W'(MAX_SNOOZE) : snz_left_d;
        ringing_d  = (state_d == RING);
        snoozed_d  = (state_d == SNOOZE);
        buzz_d     = ringing_d & beep_d;
    end

    // State, counters and registered outputs.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state_q    <= IDLE;
            ring_cnt_q <= '0;
            snz_cnt_q  <= '0;
            snz_left_q <= SNZ_W'(MAX_SNOOZE);
            beep_q     <= 1'b0;
            match_q    <= 1'b0;
            ringing_q  <= 1'b0;
            snoozed_q  <= 1'b0;
            buzz_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ring_cnt_q <= ring_cnt_d;
            snz_cnt_q  <= snz_cnt_d;
            snz_left_q <= snz_left_d;
            beep_q     <= beep_d;
            match_q    <= match_d;
            ringing_q  <= ringing_d;
            snoozed_q  <= snoozed_d;
            buzz_q     <= buzz_d;
        end
    end

    assign bus.BUZZ        = buzz_q;
    assign bus.RINGING     = ringing_q;
    assign bus.SNOOZED     = snoozed_q;
    assign bus.SNOOZE_LEFT = snz_left_q;

endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// Self-checking bench for alarm_ring_ctrl: table-driven vectors plus hand-written corner sequences.
module tb_alarm_ring_ctrl;
    import alarm_pkg::*;

    typedef struct {
        logic              rstn;
        logic              tick;
        logic              en;
        logic              stop;
        logic              snz;
        logic [TIME_W-1:0] cur;
        logic              ring;
        logic              snzd;
        logic              buzz;
        logic [1:0]        left;
    } vec_t;

    logic CLK = 1'b0;
    logic RESETN;
    int   n_vec = 0;
    int   n_err = 0;
    vec_t table_q[$];
    vec_t exp_q[$];
    logic [TIME_W-1:0] t0, t1, tm;

    alarm_ring_ctrl_if #(.SNZ_W(2)) bus ();

    alarm_ring_ctrl #(
        .RING_SEC(4), .SNOOZE_SEC(3), .MAX_SNOOZE(2), .SNZ_W(2)
    ) dut (
        .CLK(CLK),
        .RESETN(RESETN),
        .bus(bus.slave)
    );

    always #5 CLK = ~CLK;

    task automatic add(input logic rstn, input logic tick, input logic en, input logic stop,
                       input logic snz, input logic [TIME_W-1:0] cur, input logic ring,
                       input logic snzd, input logic buzz, input logic [1:0] left);
        vec_t v;
        v.rstn = rstn; v.tick = tick; v.en = en; v.stop = stop; v.snz = snz; v.cur = cur;
        v.ring = ring; v.snzd = snzd; v.buzz = buzz; v.left = left;
        table_q.push_back(v);
    endtask

    task automatic chk(input string nm, input int idx, input logic [1:0] act, input logic [1:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s vec %0d: got %0d expected %0d", nm, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        vec_t e;
        RESETN         = v.rstn;
        bus.TICK       = v.tick;
        bus.ALARM_EN   = v.en;
        bus.STOP_BTN   = v.stop;
        bus.SNOOZE_BTN = v.snz;
        bus.CUR_TIME   = v.cur;
        exp_q.push_back(v);
        @(posedge CLK);
        #1;
        e = exp_q.pop_front();
        chk("RINGING",     n_vec, {1'b0, bus.RINGING}, {1'b0, e.ring});
        chk("SNOOZED",     n_vec, {1'b0, bus.SNOOZED}, {1'b0, e.snzd});
        chk("BUZZ",        n_vec, {1'b0, bus.BUZZ},    {1'b0, e.buzz});
        chk("SNOOZE_LEFT", n_vec, bus.SNOOZE_LEFT,     e.left);
        n_vec++;
    endtask

    task automatic step(input logic rstn, input logic tick, input logic en, input logic stop,
                        input logic snz, input logic [TIME_W-1:0] cur, input logic ring,
                        input logic snzd, input logic buzz, input logic [1:0] left);
        vec_t v;
        v.rstn = rstn; v.tick = tick; v.en = en; v.stop = stop; v.snz = snz; v.cur = cur;
        v.ring = ring; v.snzd = snzd; v.buzz = buzz; v.left = left;
        apply(v);
    endtask

    // Bring the alarm from idle into a fresh ring event.
    task automatic arm();
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, t0, 1'b0, 1'b0, 1'b0, 2'd2);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, t1, 1'b1, 1'b0, 1'b1, 2'd2);
    endtask

    initial begin
        t0 = pack_time(1'b0, 5'd7, 6'd29, 6'd59);
        t1 = pack_time(1'b0, 5'd7, 6'd30, 6'd0);
        bus.ALARM_TIME = t1[ALARM_W-1:0];

        // Reset, then basic ring with 1,0,1,0 buzz pattern and timeout on the 4th tick.
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, t0, 1'b0, 1'b0, 1'b0, 2'd2);
        add(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, t0, 1'b0, 1'b0, 1'b0, 2'd2);
        add(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, t0, 1'b0, 1'b0, 1'b0, 2'd2);
        add(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, t1, 1'b1, 1'b0, 1'b1, 2'd2);
        for (int s = 0; s < 4; s++) begin
            for (int k = 0; k < 3; k++) begin
                add(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, t1, 1'b1, 1'b0, s[0] ? 1'b0 : 1'b1, 2'd2);
            end
            add(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, t1, (s == 3) ? 1'b0 : 1'b1, 1'b0,
                (s == 3) ? 1'b0 : (s[0] ? 1'b1 : 1'b0), 2'd2);
        end
        // Holding the alarm time must not retrigger.
        add(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, t1, 1'b0, 1'b0, 1'b0, 2'd2);
        add(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, t1, 1'b0, 1'b0, 1'b0, 2'd2);
        // Stop during ring.
        add(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, t0, 1'b0, 1'b0, 1'b0, 2'd2);
        add(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, t1, 1'b1, 1'b0, 1'b1, 2'd2);
        add(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, t1, 1'b0, 1'b0, 1'b0, 2'd2);
        add(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, t1, 1'b0, 1'b0, 1'b0, 2'd2);
        add(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, t1, 1'b0, 1'b0, 1'b0, 2'd2);

        for (int i = 0; i < table_q.size(); i++) begin
            apply(table_q[i]);
        end

        // Snooze cycle down to zero snoozes, then an ignored snooze and a stop.
        arm();
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, t1, 1'b0, 1'b1, 1'b0, 2'd1);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, t1, 1'b0, 1'b1, 1'b0, 2'd1);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, t1, 1'b0, 1'b1, 1'b0, 2'd1);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, t1, 1'b0, 1'b1, 1'b0, 2'd1);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, t1, 1'b0, 1'b1, 1'b0, 2'd1);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, t1, 1'b1, 1'b0, 1'b1, 2'd1);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, t1, 1'b1, 1'b0, 1'b0, 2'd1);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, t1, 1'b0, 1'b1, 1'b0, 2'd0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, t1, 1'b0, 1'b1, 1'b0, 2'd0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, t1, 1'b0, 1'b1, 1'b0, 2'd0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, t1, 1'b1, 1'b0, 1'b1, 2'd0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, t1, 1'b1, 1'b0, 1'b1, 2'd0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, t1, 1'b1, 1'b0, 1'b0, 2'd0);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, t1, 1'b0, 1'b0, 1'b0, 2'd2);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, t1, 1'b0, 1'b0, 1'b0, 2'd2);

        // Simultaneous stop and snooze: stop wins.
        arm();
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, t1, 1'b0, 1'b0, 1'b0, 2'd2);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, t1, 1'b0, 1'b0, 1'b0, 2'd2);

        // Disarm during snooze: no re-ring after the snooze period.
        arm();
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, t1, 1'b0, 1'b1, 1'b0, 2'd1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, t1, 1'b0, 1'b0, 1'b0, 2'd2);
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, t1, 1'b0, 1'b0, 1'b0, 2'd2);
        end

        // Reset mid-ring, then meridian-flagged time still matches.
        arm();
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, t1, 1'b0, 1'b0, 1'b0, 2'd2);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, t0, 1'b0, 1'b0, 1'b0, 2'd2);
        tm = pack_time(1'b1, 5'd7, 6'd30, 6'd0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, tm, 1'b1, 1'b0, 1'b1, 2'd2);
        // Changing the alarm time mid-ring leaves the current event running.
        bus.ALARM_TIME = t0[ALARM_W-1:0];
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, tm, 1'b1, 1'b0, 1'b0, 2'd2);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, tm, 1'b1, 1'b0, 1'b1, 2'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alarm_ring_ctrl.md
Name: alarm_ring_ctrl

Overview:
- Downstream consumer of the time/date counter's time and alarm-time outputs.
- Detects when the running time equals the stored alarm time, then drives the buzzer for a bounded ring period.
- Supports stop and snooze (with a snooze limit) from user buttons.
- Sits between the time counter and the buzzer/LED driver; paced by the same 1 Hz second tick that advances SEC.

Parameters:
- RING_SEC, 60: ring duration in ticks before auto-stop.
- SNOOZE_SEC, 300: snooze delay in ticks before re-ring.
- MAX_SNOOZE, 3: snoozes allowed per alarm event.
- SNZ_W, 2: width of the SNOOZE_LEFT output (must hold MAX_SNOOZE).

Ports:
- CLK  in  1  system clock
- RESETN  in  1  reset, synchronous, active-low
- TICK  in  1  one-cycle pulse per second (same cycle the counter advances SEC)
- CUR_TIME  in  18  [17] meridian, [16:12] hour (0-23), [11:6] min, [5:0] sec
- ALARM_TIME  in  17  [16:12] hour, [11:6] min, [5:0] sec
- ALARM_EN  in  1  level; 0 disarms and cancels any ring or snooze
- STOP_BTN  in  1  debounced level, rising edge used
- SNOOZE_BTN  in  1  debounced level, rising edge used
- BUZZ  out  1  buzzer drive, 1 s on / 1 s off while ringing
- RINGING  out  1  state is RING
- SNOOZED  out  1  state is SNOOZE
- SNOOZE_LEFT  out  SNZ_W  snoozes remaining

Behaviour:
- Reset (RESETN=0 at posedge CLK) from any state:
  - state IDLE; BUZZ=0, RINGING=0, SNOOZED=0, SNOOZE_LEFT=MAX_SNOOZE.
  - All counters and edge registers cleared.
  - Reset mid-ring or mid-snooze behaves identically.
- Match: match = ALARM_EN & (CUR_TIME[16:0] == ALARM_TIME). Meridian bit ignored; hour is 24 h.
- Match edge: match_q is the registered match; rise = match & ~match_q.
  - Input stays equal for a whole second, so only the rising edge triggers.
  - One trigger per alarm second.
- Button edges: btn & ~btn_q on STOP_BTN and SNOOZE_BTN, registered internally.
- All outputs are registered and decoded from the state register.
- FSM states:
  - IDLE:
    - rise -> RING on the next edge; RINGING=1 one cycle after the matching CUR_TIME is presented.
    - On entry from rise: ring_cnt=0, beep phase=1, SNOOZE_LEFT=MAX_SNOOZE.
  - RING:
    - Each TICK: ring_cnt+1 and toggle beep phase.
    - TICK with ring_cnt==RING_SEC-1 -> IDLE (timeout).
    - stop edge -> IDLE.
    - snooze edge with SNOOZE_LEFT>0 -> SNOOZE: snz_cnt=SNOOZE_SEC, SNOOZE_LEFT-1.
    - snooze edge with SNOOZE_LEFT==0: ignored, keeps ringing.
  - SNOOZE:
    - Each TICK: snz_cnt-1.
    - TICK with snz_cnt==1 -> RING: ring_cnt=0, beep phase=1, SNOOZE_LEFT preserved.
    - stop edge -> IDLE.
    - snooze edge: ignored.
- Output decode: BUZZ = (state==RING) & beep phase.
- ALARM_EN=0 in any state: -> IDLE on the next edge, BUZZ=0.
- Priority when events coincide, highest first: RESETN, ALARM_EN=0, stop edge, snooze edge, TICK-driven timeout/expiry.
- Rise while in RING or SNOOZE: ignored.
- ALARM_TIME changed during RING/SNOOZE: no effect on the current event.
- Return to IDLE restores SNOOZE_LEFT=MAX_SNOOZE.
- Counter widths: $clog2(RING_SEC+1) and $clog2(SNOOZE_SEC+1); no wrap is reachable.

Decomposition:
- Shared package alarm_pkg:
  - state enum {IDLE, RING, SNOOZE}.
  - localparam bit-field offsets for the time word (MERIDIAN_BIT=17, HOUR_MSB/LSB=16/12, MIN_MSB/LSB=11/6, SEC_MSB/LSB=5/0).
  - The time counter is to adopt the same package.
- One sub-module, btn_edge: single register plus rising-edge pulse; instantiated twice (stop, snooze).

Test Plan:
- Bench parameters for all scenarios: RING_SEC=4, SNOOZE_SEC=3, MAX_SNOOZE=2; TICK every 4 clocks.
1. Basic ring and timeout:
   - ALARM_TIME=07:30:00, ALARM_EN=1, CUR_TIME steps 07:29:59 -> 07:30:00.
   - RINGING=1 next cycle; BUZZ pattern 1,0,1,0 over ticks; IDLE after the 4th TICK.
   - No retrigger while CUR_TIME holds 07:30:00.
2. Stop: STOP_BTN rises during RING -> RINGING=0 and BUZZ=0 on the next edge; SNOOZE_LEFT=2.
3. Snooze cycle:
   - First snooze press -> SNOOZED=1, SNOOZE_LEFT=1.
   - After 3 TICKs -> RINGING=1, SNOOZE_LEFT stays 1.
   - Second snooze -> SNOOZE_LEFT=0; third snooze in RING is ignored, still ringing.
4. Simultaneous STOP_BTN and SNOOZE_BTN rise in RING -> IDLE, SNOOZE_LEFT=2.
5. Disarm: ALARM_EN 1->0 during SNOOZE -> IDLE next edge, and no re-ring after 3 TICKs.
6. Reset mid-operation and meridian:
   - RESETN=0 for one cycle during RING -> all outputs at reset values.
   - CUR_TIME meridian bit=1 with matching hour/min/sec still triggers RING.
